// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-producer writeback FIFOs drained round-robin,
// one registered result per cycle onto the CDB, with flush and pause.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 5
`endif

module cdb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int ID_W       = `ROB_WIDTH_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*ID_W-1:0] req_rob_id,
    input  logic [NUM_REQ*32-1:0]   req_value,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    cdb_valid,
    output logic [ID_W-1:0]         cdb_rob_id,
    output logic [31:0]             cdb_value,
    output logic [2:0]              cdb_src
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(NUM_REQ);
    localparam int EW = ID_W + 32;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [EW-1:0]      mem_q   [NUM_REQ][FIFO_DEPTH];
    logic [PW-1:0]      wptr_q  [NUM_REQ];
    logic [PW-1:0]      rptr_q  [NUM_REQ];
    logic [CW-1:0]      count_q [NUM_REQ];
    logic [SW-1:0]      rr_ptr_q;
    logic [SW-1:0]      rr_ptr_d;
    logic               cdb_valid_q;
    logic [ID_W-1:0]    cdb_rob_id_q;
    logic [31:0]        cdb_value_q;
    logic [2:0]         cdb_src_q;

    logic [NUM_REQ-1:0] push_s;
    logic [NUM_REQ-1:0] pop_s;
    logic               found_s;
    logic [SW-1:0]      win_s;
    logic [EW-1:0]      head_s;

    // Ready depends on registered counts only, so reset raises it immediately.
    always_comb begin
        req_ready = '0;
        push_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (count_q[i] != FULL_CNT);
            push_s[i]    = rdy_in & ~flush_in & req_valid[i] & req_ready[i];
        end
    end

    // Round-robin pick among non-empty FIFOs, scanning upward from rr_ptr.
    always_comb begin
        logic [SW:0]   sum;
        logic [SW-1:0] idx;
        found_s = 1'b0;
        win_s   = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (sum >= (SW+1)'(NUM_REQ)) begin
                sum = sum - (SW+1)'(NUM_REQ);
            end else begin
                sum = sum;
            end
            idx = sum[SW-1:0];
            if (!found_s && (count_q[idx] != '0)) begin
                found_s = 1'b1;
                win_s   = idx;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pop strobes, winner head entry and next round-robin pointer.
    always_comb begin
        pop_s  = '0;
        head_s = mem_q[win_s][rptr_q[win_s]];
        for (int i = 0; i < NUM_REQ; i++) begin
            pop_s[i] = rdy_in & ~flush_in & found_s & (win_s == SW'(i));
        end
        if (!found_s) begin
            rr_ptr_d = rr_ptr_q;
        end else if (win_s == SW'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = win_s + SW'(1);
        end
    end

    // FIFO payload storage; data needs no reset since counts gate its use.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push_s[i]) begin
                mem_q[i][wptr_q[i]] <= {req_rob_id[i*ID_W +: ID_W], req_value[i*32 +: 32]};
            end
        end
    end

    // FIFO pointers and occupancy; a same-edge push and pop leaves count unchanged.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush_in) begin
                    wptr_q[i]  <= '0;
                    rptr_q[i]  <= '0;
                    count_q[i] <= '0;
                end else begin
                    if (push_s[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
                    if (pop_s[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
                    count_q[i] <= count_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
                end
            end
        end
    end

    // CDB output registers and round-robin pointer; flush keeps rr_ptr.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= 32'd0;
            cdb_src_q    <= 3'd0;
            rr_ptr_q     <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                cdb_valid_q <= 1'b0;
            end else if (found_s) begin
                cdb_valid_q  <= 1'b1;
                cdb_rob_id_q <= head_s[EW-1:32];
                cdb_value_q  <= head_s[31:0];
                cdb_src_q    <= 3'(win_s);
                rr_ptr_q     <= rr_ptr_d;
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_value  = cdb_value_q;
    assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (3 producers, depth-2 FIFOs, 5-bit ROB ids).
module tb_cdb_arbiter;
    localparam int NUM_REQ    = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int ID_W       = 5;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic                    rdy_in;
    logic                    flush_in;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*ID_W-1:0] req_rob_id;
    logic [NUM_REQ*32-1:0]   req_value;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    cdb_valid;
    logic [ID_W-1:0]         cdb_rob_id;
    logic [31:0]             cdb_value;
    logic [2:0]              cdb_src;

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .req_valid(req_valid), .req_rob_id(req_rob_id), .req_value(req_value),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] val_of(input int id);
        return 32'hCAFE_0000 + 32'(id);
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr_req();
        req_valid  = '0;
        req_rob_id = '0;
        req_value  = '0;
    endtask

    task automatic set_req(input int i, input int id);
        req_valid[i]              = 1'b1;
        req_rob_id[i*ID_W +: ID_W] = ID_W'(id);
        req_value[i*32 +: 32]      = val_of(id);
    endtask

    task automatic do_reset();
        clr_req();
        flush_in = 1'b0;
        rdy_in   = 1'b1;
        rst_in   = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_req(0, 1); set_req(1, 2); set_req(2, 3);
        step();
        set_req(0, 4); set_req(1, 5); set_req(2, 6);
        step();
        clr_req();
        n_cmp++;
        if ({req_ready, cdb_valid} !== {3'b001, 1'b1}) begin
            n_err++; $display("FAIL pre_reset_state: got ready=%b valid=%b want ready=001 valid=1", req_ready, cdb_valid);
        end
        #2;
        rst_in = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src} !== {3'b111, 1'b0, 5'd0, 32'd0, 3'd0}) begin
            n_err++; $display("FAIL async_reset: got ready=%b v=%b id=%0d val=%h src=%0d want 111/0/0/0/0",
                              req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src);
        end
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (cdb_valid !== 1'b0) begin
                n_err++; $display("FAIL idle_after_reset: cycle %0d got valid=%b want 0", c, cdb_valid);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 5);
        req_value[31:0] = 32'hDEAD_BEEF;
        step();
        clr_req();
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_err++; $display("FAIL single_latency: got valid=%b want 0", cdb_valid);
        end
        step();
        n_cmp++;
        if ({cdb_valid, cdb_rob_id, cdb_value, cdb_src} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0}) begin
            n_err++; $display("FAIL single_cdb: got v=%b id=%0d val=%h src=%0d want 1/5/deadbeef/0",
                              cdb_valid, cdb_rob_id, cdb_value, cdb_src);
        end
        step();
        n_cmp++;
        if ({cdb_valid, dut.rr_ptr_q} !== {1'b0, 2'd1}) begin
            n_err++; $display("FAIL single_pulse: got valid=%b rr=%0d want 0/1", cdb_valid, dut.rr_ptr_q);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int p = 0; p < NUM_REQ; p++) set_req(p, rep*3 + p + 1);
            step();
            clr_req();
            for (int k = 0; k < NUM_REQ; k++) begin
                step();
                n_cmp++;
                if ({cdb_valid, cdb_rob_id, cdb_value, cdb_src} !==
                    {1'b1, ID_W'(rep*3 + k + 1), val_of(rep*3 + k + 1), 3'(k)}) begin
                    n_err++; $display("FAIL rr_grant: rep %0d slot %0d got v=%b id=%0d src=%0d want id=%0d src=%0d",
                                      rep, k, cdb_valid, cdb_rob_id, cdb_src, rep*3 + k + 1, k);
                end
            end
            n_cmp++;
            if (dut.rr_ptr_q !== 2'd0) begin
                n_err++; $display("FAIL rr_wrap: got rr=%0d want 0", dut.rr_ptr_q);
            end
            step();
            n_cmp++;
            if (cdb_valid !== 1'b0) begin
                n_err++; $display("FAIL rr_drain: got valid=%b want 0", cdb_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            clr_req();
            if (e <= 6) set_req(2, e);
            step();
            n_cmp++;
            if (e >= 2 && e <= 7) begin
                if ({cdb_valid, cdb_rob_id, cdb_value, cdb_src, req_ready} !==
                    {1'b1, ID_W'(e - 1), val_of(e - 1), 3'd2, 3'b111}) begin
                    n_err++; $display("FAIL b2b_stream: edge %0d got v=%b id=%0d src=%0d rdy=%b want 1/%0d/2/111",
                                      e, cdb_valid, cdb_rob_id, cdb_src, req_ready, e - 1);
                end
            end else if (cdb_valid !== 1'b0) begin
                n_err++; $display("FAIL b2b_idle: edge %0d got valid=%b want 0", e, cdb_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int seq [8] = '{20, 8, 21, 9, 22, 10, 23, 11};
        int p0_next = 20, p1_next = 8, p0_exp = 20, p1_exp = 8;
        int outs = 0, idx = 0;
        bit acc0, acc1, seen_full = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 40 && outs < 11; cyc++) begin
            clr_req();
            acc0 = (p0_next <= 25) && req_ready[0];
            acc1 = (p1_next <= 12) && req_ready[1];
            if (p0_next <= 25) set_req(0, p0_next);
            if (p1_next <= 12) set_req(1, p1_next);
            if (!req_ready[1]) seen_full = 1'b1;
            step();
            if (acc0) p0_next++;
            if (acc1) p1_next++;
            if (cdb_valid) begin
                outs++;
                if (idx < 8) begin
                    n_cmp++;
                    if (cdb_rob_id !== ID_W'(seq[idx])) begin
                        n_err++; $display("FAIL bp_sequence: grant %0d got id=%0d want %0d", idx, cdb_rob_id, seq[idx]);
                    end
                    idx++;
                end
                n_cmp++;
                if (cdb_src == 3'd0 && cdb_rob_id === ID_W'(p0_exp) && cdb_value === val_of(p0_exp)) begin
                    p0_exp++;
                end else if (cdb_src == 3'd1 && cdb_rob_id === ID_W'(p1_exp) && cdb_value === val_of(p1_exp)) begin
                    p1_exp++;
                end else begin
                    n_err++; $display("FAIL bp_order: got src=%0d id=%0d want p0 id %0d or p1 id %0d",
                                      cdb_src, cdb_rob_id, p0_exp, p1_exp);
                end
            end
        end
        clr_req();
        n_cmp++;
        if (outs != 11 || p0_exp != 26 || p1_exp != 13 || !seen_full) begin
            n_err++; $display("FAIL bp_totals: got outs=%0d p0=%0d p1=%0d full=%0b want 11/26/13/1",
                              outs, p0_exp, p1_exp, seen_full);
        end
        step();
        n_cmp++;
        if ({cdb_valid, dut.wptr_q[1], dut.rptr_q[1], dut.count_q[1]} !== {1'b0, 1'b1, 1'b1, 2'd0}) begin
            n_err++; $display("FAIL bp_wrap: got v=%b wptr=%0d rptr=%0d cnt=%0d want 0/1/1/0",
                              cdb_valid, dut.wptr_q[1], dut.rptr_q[1], dut.count_q[1]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_req(0, 10); set_req(2, 30);
        step();
        clr_req(); set_req(0, 11); set_req(2, 31);
        step();
        n_cmp++;
        if ({cdb_valid, cdb_rob_id, cdb_src} !== {1'b1, 5'd10, 3'd0}) begin
            n_err++; $display("FAIL flush_setup_a: got v=%b id=%0d src=%0d want 1/10/0", cdb_valid, cdb_rob_id, cdb_src);
        end
        clr_req(); set_req(0, 12);
        step();
        n_cmp++;
        if ({cdb_valid, cdb_rob_id, cdb_src, req_ready} !== {1'b1, 5'd30, 3'd2, 3'b110}) begin
            n_err++; $display("FAIL flush_setup_b: got v=%b id=%0d src=%0d rdy=%b want 1/30/2/110",
                              cdb_valid, cdb_rob_id, cdb_src, req_ready);
        end
        clr_req(); set_req(1, 40);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        clr_req();
        n_cmp++;
        if ({cdb_valid, req_ready, dut.rr_ptr_q} !== {1'b0, 3'b111, 2'd0}) begin
            n_err++; $display("FAIL flush_clear: got v=%b rdy=%b rr=%0d want 0/111/0", cdb_valid, req_ready, dut.rr_ptr_q);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (cdb_valid !== 1'b0) begin
                n_err++; $display("FAIL flush_leak: cycle %0d got valid=%b id=%0d want 0", c, cdb_valid, cdb_rob_id);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        set_req(0, 4); set_req(1, 6);
        step();
        clr_req();
        step();
        n_cmp++;
        if ({cdb_valid, cdb_rob_id, cdb_src} !== {1'b1, 5'd4, 3'd0}) begin
            n_err++; $display("FAIL pause_setup: got v=%b id=%0d src=%0d want 1/4/0", cdb_valid, cdb_rob_id, cdb_src);
        end
        rdy_in = 1'b0;
        set_req(0, 20); set_req(1, 21); set_req(2, 22);
        for (int c = 0; c < 3; c++) begin
            flush_in = (c == 1);
            step();
            n_cmp++;
            if ({cdb_valid, cdb_rob_id, cdb_value, cdb_src, dut.rr_ptr_q,
                 dut.count_q[0], dut.count_q[1], dut.count_q[2]} !==
                {1'b1, 5'd4, val_of(4), 3'd0, 2'd1, 2'd0, 2'd1, 2'd0}) begin
                n_err++; $display("FAIL pause_hold: cycle %0d got v=%b id=%0d src=%0d rr=%0d cnt=%0d/%0d/%0d want 1/4/0/1 cnt 0/1/0",
                                  c, cdb_valid, cdb_rob_id, cdb_src, dut.rr_ptr_q,
                                  dut.count_q[0], dut.count_q[1], dut.count_q[2]);
            end
        end
        flush_in = 1'b0;
        rdy_in   = 1'b1;
        clr_req();
        step();
        n_cmp++;
        if ({cdb_valid, cdb_rob_id, cdb_value, cdb_src} !== {1'b1, 5'd6, val_of(6), 3'd1}) begin
            n_err++; $display("FAIL pause_resume: got v=%b id=%0d src=%0d want 1/6/1", cdb_valid, cdb_rob_id, cdb_src);
        end
        step();
        n_cmp++;
        if ({cdb_valid, dut.count_q[0], dut.count_q[1], dut.count_q[2]} !== {1'b0, 2'd0, 2'd0, 2'd0}) begin
            n_err++; $display("FAIL pause_nopush: got v=%b cnt=%0d/%0d/%0d want 0 cnt 0/0/0",
                              cdb_valid, dut.count_q[0], dut.count_q[1], dut.count_q[2]);
        end
    endtask

    initial begin
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        clr_req();
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the execution-side producers (ALU, load/store buffer, branch unit) that write results back to ROB entries. Each producer pushes {ROB id, 32-bit value} into a small private FIFO. One winner per cycle is registered onto the CDB, which the ROB and reservation stations snoop. A flush input empties all pending writebacks on misprediction.

## Interface
- NUM_REQ, 3, number of producers (index 0 = ALU, 1 = LSB, 2 = branch); 2..8
- FIFO_DEPTH, 2, entries per producer FIFO; power of 2, >= 2
- ID_W, `ROB_WIDTH_BIT, ROB id width
- clk_in  input  1  clock; all state changes on the rising edge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  pause when low; all state holds
- flush_in  input  1  discard all pending and in-flight writebacks
- req_valid  input  NUM_REQ  producer i offers a result
- req_rob_id  input  NUM_REQ*ID_W  ROB id, producer i at bits [i*ID_W +: ID_W]
- req_value  input  NUM_REQ*32  result value, producer i at bits [i*32 +: 32]
- req_ready  output  NUM_REQ  FIFO i not full; registered-state only, no combinational path from req_valid
- cdb_valid  output  1  CDB carries a result this cycle
- cdb_rob_id  output  ID_W  destination ROB entry
- cdb_value  output  32  result value
- cdb_src  output  3  index of the producer that won

## Operation
- Per producer: a FIFO of FIFO_DEPTH entries with read and write pointers plus a count (width log2(FIFO_DEPTH)+1). Pointers wrap modulo FIFO_DEPTH.
- req_ready[i] = (count[i] != FIFO_DEPTH).
- Push: at an edge where rdy_in=1, flush_in=0, req_valid[i]=1 and req_ready[i]=1, write {rob_id, value} at the write pointer. req_valid while not ready is ignored; the producer holds its data.
- Arbitration, at every edge where rdy_in=1 and flush_in=0:
  - Candidates are the FIFOs with count != 0, taken from pre-edge state. An entry pushed at this edge is not a candidate.
  - Winner = first candidate at or after rr_ptr, scanning upward with wrap.
  - Pop the winner's head and load the CDB registers: cdb_valid=1, cdb_rob_id, cdb_value, cdb_src=winner.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - No candidate: cdb_valid <= 0. cdb_rob_id, cdb_value and cdb_src hold. rr_ptr holds.
- Simultaneous push and pop on the same FIFO: both happen and count is unchanged. A full FIFO stays not-ready in that cycle even though it pops.
- Flush, at an edge with rdy_in=1 and flush_in=1:
  - All counts and pointers go to 0.
  - Pushes at that edge are dropped.
  - cdb_valid <= 0.
  - rr_ptr holds.
- rdy_in=0: no push, no pop, every register holds, including cdb_valid (consumers are paused too). flush_in is ignored while rdy_in=0.
- Each FIFO entry is written to the CDB exactly once. Order is preserved within a producer; there is no ordering across producers.

## Timing
- Reset (rst_in low, asynchronous) forces:
  - cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0
  - all counts and pointers 0, rr_ptr=0
  - req_ready = all ones, within the same cycle as reset assertion
- Reset takes effect mid-operation and discards buffered results. Release is synchronous to the next clk_in edge through the normal flop path.
- Latency: a result pushed at edge E appears on the CDB, at the earliest, in the cycle after edge E+1. Minimum 1 cycle in the FIFO.
- Throughput: one CDB result per cycle. A single producer pushing every cycle with no competitors sustains one result per cycle once its FIFO is non-empty.
- Fairness: with all NUM_REQ FIFOs continuously non-empty, each producer wins exactly once per NUM_REQ cycles.
- cdb_valid is a per-cycle pulse. Back-to-back grants keep it high with new data each cycle.

## Test plan
- Reset then idle: after asynchronous rst_in low mid-cycle, req_ready=3'b111 and cdb_valid=0 immediately. With no requests for 10 cycles, cdb_valid stays 0.
- Single push: ALU pushes rob_id=5, value=0xDEADBEEF at edge 1. At edge 2 the CDB loads {5, 0xDEADBEEF, src=0}. cdb_valid is high for exactly one cycle.
- Round-robin: all three producers push at the same edge (ids 1, 2, 3). CDB sources come out 0, 1, 2 on consecutive cycles and rr_ptr returns to 0. Refilling and repeating gives the same rotation.
- Backpressure and wrap: producer 1 pushes 5 results (ids 8..12) every cycle while producer 0 also streams continuously. req_ready[1] drops while its FIFO is full. All 5 ids appear in order with no loss or duplication, and the pointers wrap past FIFO_DEPTH.
- Flush: fill FIFO 0 with 2 entries and FIFO 2 with 1 entry, then pulse flush_in together with a new push on producer 1. Next cycle cdb_valid=0. Nothing from the flushed entries or the dropped push ever appears, and req_ready=3'b111.
- Pause: with cdb_valid=1 showing id 4, hold rdy_in low for 3 cycles while producers assert req_valid. The CDB outputs, FIFO counts and rr_ptr are frozen. After rdy_in returns high, arbitration resumes with no pushes taken during the pause.
